// File: rtl/gp_timer_pkg.sv
// gp_timer_pkg: register offsets, CTRL field positions and byte-lane merge helper for gp_timer_bank.
// Latency: none (declarations only).
// Backpressure: none.
package gp_timer_pkg;

    // Word offsets within a channel's 4-register window
    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_COMPARE = 2'd1;
    localparam logic [1:0] REG_COUNT   = 2'd2;
    localparam logic [1:0] REG_CAPTURE = 2'd3;

    // CTRL bit positions
    localparam int CTRL_EN        = 0;
    localparam int CTRL_PERIODIC  = 1;
    localparam int CTRL_IRQEN     = 2;
    localparam int CTRL_CLR       = 3;
    localparam int CTRL_ACK       = 4;
    localparam int CTRL_PEND      = 5;
    localparam int CTRL_CAPPEND   = 6;
    localparam int CTRL_CAPACK    = 7;
    localparam int CTRL_PRESC_LSB = 8;

    // Replace only the byte lanes whose enable is set
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = old_val;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) r[8*k +: 8] = new_val[8*k +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/gp_timer_channel.sv
// gp_timer_channel: one timer channel (prescaler, counter, compare, pending, optional capture).
// Latency: pending/irq visible the cycle after the tick edge; rdata is combinational.
// Backpressure: none; register writes are always accepted in the cycle presented.
// Ports: input_clk/reset; wr_en (decoded write for this channel), reg_sel, we, wdata;
//        cap_in capture strobe; rdata read data for reg_sel; irq = pending event && irq_en.
// Optional capture unit enabled by the TIMER_CAPTURE_EN macro.
module gp_timer_channel
    import gp_timer_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int PRESCALE_W = 8
) (
    input  logic        input_clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [1:0]  reg_sel,
    input  logic [3:0]  we,
    input  logic [31:0] wdata,
    input  logic        cap_in,
    output logic [31:0] rdata,
    output logic        irq
);

    logic                  en, en_nxt, periodic, irq_en, pending;
    logic [PRESCALE_W-1:0] presc, pcnt;
    logic [WIDTH-1:0]      compare, count;
    logic                  cap_pending;
    logic [WIDTH-1:0]      capture;

    logic        ctrl_lo, ctrl_hi, clr, ack, wr_cmp, wr_cnt, tick, match;
    logic [31:0] cmp_merge, cnt_merge;
    logic        unused_bits;

    assign ctrl_lo = wr_en && (reg_sel == REG_CTRL) && we[0];
    assign ctrl_hi = wr_en && (reg_sel == REG_CTRL) && we[1];
    assign clr     = ctrl_lo && wdata[CTRL_CLR];
    assign ack     = ctrl_lo && wdata[CTRL_ACK];
    assign wr_cmp  = wr_en && (reg_sel == REG_COMPARE);
    assign wr_cnt  = wr_en && (reg_sel == REG_COUNT);

    assign cmp_merge = byte_merge(32'(compare), wdata, we);
    assign cnt_merge = byte_merge(32'(count), wdata, we);
    // Bits above WIDTH and read-only CTRL bits are intentionally dropped
    assign unused_bits = ^{wdata, cmp_merge, cnt_merge};

    assign tick  = en && (pcnt == presc);
    assign match = tick && (count == compare);

    // A bus write to enable wins over the one-shot self-disable
    always_comb begin
        en_nxt = en;
        if (ctrl_lo)                 en_nxt = wdata[CTRL_EN];
        else if (match && !periodic) en_nxt = 1'b0;
    end

    always_ff @(posedge input_clk or posedge reset) begin
        if (reset) begin
            en       <= 1'b0;
            periodic <= 1'b0;
            irq_en   <= 1'b0;
            pending  <= 1'b0;
            presc    <= '0;
            pcnt     <= '0;
            compare  <= '1;
            count    <= '0;
        end else begin
            en <= en_nxt;
            if (ctrl_lo) begin
                periodic <= wdata[CTRL_PERIODIC];
                irq_en   <= wdata[CTRL_IRQEN];
            end
            if (ctrl_hi) presc <= wdata[CTRL_PRESC_LSB +: PRESCALE_W];
            if (wr_cmp)  compare <= cmp_merge[WIDTH-1:0];

            // Prescaler only advances while enabled now and next cycle
            if (en && en_nxt && !clr && !tick) pcnt <= pcnt + PRESCALE_W'(1);
            else                               pcnt <= '0;

            // Bus write / clear beat the tick update; a match still latches pending
            if (wr_cnt)     count <= cnt_merge[WIDTH-1:0];
            else if (clr)   count <= '0;
            else if (tick) begin
                if (!match)        count <= count + WIDTH'(1);
                else if (periodic) count <= '0;
            end

            if (match)    pending <= 1'b1;
            else if (ack) pending <= 1'b0;
        end
    end

`ifdef TIMER_CAPTURE_EN
    // Two synchroniser flops plus one history flop for edge detection
    logic [2:0] cap_sync;
    logic       cap_edge, cap_ack;

    assign cap_edge = cap_sync[1] && !cap_sync[2];
    assign cap_ack  = ctrl_lo && wdata[CTRL_CAPACK];

    always_ff @(posedge input_clk or posedge reset) begin
        if (reset) begin
            cap_sync    <= '0;
            cap_pending <= 1'b0;
            capture     <= '0;
        end else begin
            cap_sync <= {cap_sync[1:0], cap_in};
            if (cap_edge) begin
                capture     <= count;
                cap_pending <= 1'b1;
            end else if (cap_ack) begin
                cap_pending <= 1'b0;
            end
        end
    end
`else
    logic unused_cap;
    assign unused_cap  = cap_in;
    assign cap_pending = 1'b0;
    assign capture     = '0;
`endif

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_CTRL: begin
                rdata[CTRL_EN]       = en;
                rdata[CTRL_PERIODIC] = periodic;
                rdata[CTRL_IRQEN]    = irq_en;
                rdata[CTRL_PEND]     = pending;
                rdata[CTRL_CAPPEND]  = cap_pending;
                rdata[CTRL_PRESC_LSB +: PRESCALE_W] = presc;
            end
            REG_COMPARE: rdata[WIDTH-1:0] = compare;
            REG_COUNT:   rdata[WIDTH-1:0] = count;
            default:     rdata[WIDTH-1:0] = capture;
        endcase
    end

    assign irq = irq_en && (pending || cap_pending);

endmodule

// File: rtl/gp_timer_bank.sv
// gp_timer_bank: memory-mapped bank of NUM_CH general-purpose timers with a combined irq.
// Latency: rdata combinational from addr; irq_vec/irq follow channel state one cycle after the tick edge.
// Backpressure: none; a write (select && we!=0) always completes in the presented cycle.
// Ports: input_clk, reset (async, active-high); select/we/addr/wdata bus write; rdata read mux;
//        irq_vec per-channel interrupts, irq their OR; cap_in capture strobes.
// Optional capture unit per channel enabled by the TIMER_CAPTURE_EN macro.
module gp_timer_bank
    import gp_timer_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int WIDTH      = 32,
    parameter int PRESCALE_W = 8
) (
    input  logic                       input_clk,
    input  logic                       reset,
    input  logic                       select,
    input  logic [3:0]                 we,
    input  logic [$clog2(NUM_CH)+1:0]  addr,
    input  logic [31:0]                wdata,
    output logic [31:0]                rdata,
    output logic [NUM_CH-1:0]          irq_vec,
    output logic                       irq,
    input  logic [NUM_CH-1:0]          cap_in
);

    localparam int AW = $clog2(NUM_CH) + 2;

    logic [AW-1:0]     ch_idx;
    logic              wr;
    logic [NUM_CH-1:0] ch_wr;
    logic [31:0]       ch_rdata [NUM_CH];

    assign ch_idx = addr >> 2;
    assign wr     = select && (we != 4'b0);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch_wr[i] = wr && (ch_idx == AW'(i));

        gp_timer_channel #(
            .WIDTH      (WIDTH),
            .PRESCALE_W (PRESCALE_W)
        ) u_ch (
            .input_clk (input_clk),
            .reset     (reset),
            .wr_en     (ch_wr[i]),
            .reg_sel   (addr[1:0]),
            .we        (we),
            .wdata     (wdata),
            .cap_in    (cap_in[i]),
            .rdata     (ch_rdata[i]),
            .irq       (irq_vec[i])
        );
    end

    // Unpopulated channel slots read as zero
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_idx == AW'(i)) rdata = ch_rdata[i];
        end
    end

    assign irq = |irq_vec;

endmodule

// File: doc/gp_timer_bank.md
Name: gp_timer_bank

Overview:
- Parametrised, memory-mapped bank of NUM_CH independent general-purpose timers. Next generation of the single top-level GP timer.
- Adds per-channel prescaler, periodic/one-shot mode, per-channel interrupt enable, and equality-based wrap (no ">" comparison).
- Sits on the CPU bus beside the UART/SPI peripherals. Its irq output ORs into the CPU interrupt_request.

Parameters:
- NUM_CH, 4, number of timer channels (1..8).
- WIDTH, 32, counter/compare width in bits (8..32).
- PRESCALE_W, 8, width of the per-channel prescaler divisor field (1..8).

Ports:
- input_clk  in  1  system clock; all state is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- select  in  1  bus decode for this block.
- we  in  4  byte write enables; a write occurs when select && we!=0.
- addr  in  $clog2(NUM_CH)+2  word address; upper bits = channel, low 2 bits = register.
- wdata  in  32  write data.
- rdata  out  32  combinational read data for addr; unused bits read 0.
- irq_vec  out  NUM_CH  per-channel (pending && irq_en).
- irq  out  1  OR of irq_vec.
- cap_in  in  NUM_CH  capture strobes (used only with TIMER_CAPTURE_EN).

Behaviour:
- Register map per channel:
  - 0 CTRL: [0] enable, [1] periodic (1) / one-shot (0), [2] irq_en, [3] W1 clear count (reads 0), [4] W1 ack pending (reads 0), [5] pending (RO), [15:8] prescale divisor P.
  - 1 COMPARE: WIDTH bits.
  - 2 COUNT: WIDTH bits, read/write.
  - 3 CAPTURE: see optional feature.
- Byte lanes are honoured on every write (we[k] → bits 8k+7:8k). Bits above WIDTH are ignored.
- Reset values:
  - CTRL fields 0, COMPARE all-ones, COUNT 0, prescaler counter 0, pending 0.
  - rdata follows addr; irq and irq_vec are 0.
- Tick generation:
  - The prescaler counter runs only while enable=1. tick asserts when it equals P, and the counter then returns to 0.
  - P=0 ticks every cycle; P=n ticks every n+1 cycles.
  - Clearing enable zeroes the prescaler counter.
- Count, on tick:
  - If COUNT==COMPARE: pending←1. In periodic mode COUNT←0. In one-shot mode COUNT holds and enable←0.
  - Otherwise COUNT←COUNT+1, wrapping mod 2^WIDTH.
  - Period = (COMPARE+1)·(P+1) cycles.
- Match latency: pending and irq_vec are visible in the cycle after the tick edge.
- Priority within a cycle:
  - Bus write to COUNT or a CTRL clear beats tick increment/reload. A clear also zeroes the prescaler counter.
  - A match setting pending beats a simultaneous ack, so no event is lost.
- COMPARE written below the current COUNT: the counter runs on, wraps through 2^WIDTH−1→0, then matches. No early fire.
- irq_en=0 masks irq_vec only; pending still latches.
- Reset mid-count: everything returns to reset values asynchronously, and irq drops immediately.
- Channels are fully independent. Simultaneous matches on several channels all latch.

Optional Feature:
- Macro: TIMER_CAPTURE_EN.
- With the macro:
  - cap_in[i] is passed through a 2-flop synchroniser, then rising-edge detected.
  - On the edge, CAPTURE←COUNT and CTRL[6] cap_pending←1.
  - CTRL[7] is W1 ack of cap_pending. Capture-set beats ack.
  - irq_vec[i] also asserts on cap_pending && irq_en.
- Without the macro: CAPTURE and CTRL[7:6] read 0, cap_in is unused, and no flops are inferred.

Decomposition:
- Package gp_timer_pkg holds:
  - register offsets REG_CTRL=0, REG_COMPARE=1, REG_COUNT=2, REG_CAPTURE=3;
  - CTRL bit positions (EN, PERIODIC, IRQEN, CLR, ACK, PEND, CAPPEND, CAPACK, PRESC_LSB).
- Sub-module gp_timer_channel holds prescaler, counter, compare, pending and capture logic.
- gp_timer_bank generates NUM_CH instances and does address decode, the rdata mux and the irq OR.

Test Plan:
- Periodic: ch0 COMPARE=9, P=0, enable+periodic+irq_en → irq rises every 10 cycles; after ack, COUNT sequence is 0..9,0.
- Prescale: ch1 COMPARE=3, P=4, periodic → pending is set every 20 cycles; COUNT steps once per 5 cycles.
- One-shot: ch2 COMPARE=5, one-shot → single pending; enable reads 0; COUNT holds 5; no further irq over 100 cycles.
- Collision and masking: ack written in the same cycle as a ch0 match → pending remains 1. With irq_en=0 and a match → irq=0 and CTRL[5]=1.
- Wrap and byte lanes: WIDTH=8, COUNT=200, COMPARE=100 → match after 157 ticks. A we=4'b0001 write to COMPARE with 0xAB changes only bits 7:0.
- Capture (TIMER_CAPTURE_EN): pulse cap_in[3] when COUNT=42 → CAPTURE reads 42 (±synchroniser delay of 3), CTRL[6]=1, irq asserts; ack clears it. Without the macro → reads 0.
